// File: rtl/rapids_wb_pkg.sv
// rapids_wb_pkg: shared types and constants for the ALU writeback block.
//   WB_WIDTH / WB_REG_BITS / WB_DEPTH : default data width, register-number width,
//                                       queue depth
//   wb_entry_t                        : one queued ALU result pair
//   wb_state_t                        : drain FSM states
//   y2_live / has_write               : which halves of an entry produce a write
package rapids_wb_pkg;

  localparam int WB_WIDTH    = 32;
  localparam int WB_REG_BITS = 5;
  localparam int WB_DEPTH    = 4;

  typedef struct packed {
    logic [WB_WIDTH-1:0]    y1;
    logic [WB_WIDTH-1:0]    y2;
    logic [WB_REG_BITS-1:0] rd1;
    logic [WB_REG_BITS-1:0] rd2;
    logic                   dual;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WR1  = 2'd1,
    WB_WR2  = 2'd2
  } wb_state_t;

  // Y2 is written only for dual entries and never to register 0.
  function automatic logic y2_live(input wb_entry_t e);
    return e.dual && (e.rd2 != '0);
  endfunction

  // An entry whose every half targets register 0 writes nothing.
  function automatic logic has_write(input wb_entry_t e);
    return (e.rd1 != '0) || y2_live(e);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of wb_entry_t.
//   clk, rst_n     : clock, synchronous active-low reset
//   push, entry_in : write entry_in at the tail
//   pop            : retire the head (caller guarantees count != 0)
//   head           : oldest entry
//   next_head      : entry behind the head (valid when count >= 2)
//   count          : entries held
//   rd_ptr, mem    : raw storage view, used by the bypass lookup
// Push while full is never requested by the caller.
module wb_fifo
  import rapids_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              entry_in,
  input  logic                   pop,
  output wb_entry_t              head,
  output wb_entry_t              next_head,
  output logic [CW-1:0]          count,
  output logic [PW-1:0]          rd_ptr,
  output wb_entry_t [DEPTH-1:0]  mem
);

  logic [PW-1:0] wr_ptr;

  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + PW'(1)];

  // Pointers wrap naturally because DEPTH is a power of two; count tells
  // full apart from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: buffers ALU Y1/Y2 result pairs and drains them one word per
// cycle into a single register-file write port.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : result pair offered / queue can accept
//   in_y1, in_y2        : result words
//   in_rd1, in_rd2      : destinations of Y1 and Y2
//   in_dual             : 1 writes both words, 0 writes Y1 only
//   wr_en/wr_addr/wr_data/wr_ack : register-file write port
//   busy, count         : queue non-empty or write pending / entries held
//   byp_addr/byp_hit/byp_data    : pending-write lookup (macro WB_BYPASS_EN)
// Handshake: a pair is taken on a rising edge where in_valid && in_ready;
// in_ready comes from registered state only, so a pop on the same edge never
// frees room for a push. A write completes on an edge where wr_en && wr_ack;
// without wr_ack, wr_en/wr_addr/wr_data hold their values.
// Optional macro: WB_BYPASS_EN adds the byp_* ports and match logic.
module alu_writeback
  import rapids_wb_pkg::*;
#(
  parameter int WIDTH    = WB_WIDTH,
  parameter int REG_BITS = WB_REG_BITS,
  parameter int DEPTH    = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_y1,
  input  logic [WIDTH-1:0]           in_y2,
  input  logic [REG_BITS-1:0]        in_rd1,
  input  logic [REG_BITS-1:0]        in_rd2,
  input  logic                       in_dual,
  output logic                       wr_en,
  output logic [REG_BITS-1:0]        wr_addr,
  output logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_ack,
  output logic                       busy,
`ifdef WB_BYPASS_EN
  input  logic [REG_BITS-1:0]        byp_addr,
  output logic                       byp_hit,
  output logic [WIDTH-1:0]           byp_data,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_t             state_q, state_d;
  wb_entry_t             entry_in, head, next_head, cand;
  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         rd_ptr;
  logic                  push, pop, load, ready_q;
  logic                  en_d;
  logic [REG_BITS-1:0]   addr_d;
  logic [WIDTH-1:0]      data_d;

  assign entry_in = '{y1: in_y1, y2: in_y2, rd1: in_rd1, rd2: in_rd2, dual: in_dual};
  // ready_q is low only during reset so in_ready reads 0 while rst_n is low.
  assign in_ready = ready_q && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (count != '0) || wr_en;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .entry_in  (entry_in),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .rd_ptr    (rd_ptr),
    .mem       (mem)
  );

  // Drain FSM. When an entry retires, the entry behind it is loaded on the
  // same edge so back-to-back entries need no idle cycle. Halves aimed at
  // register 0 are skipped when choosing what to present; an entry with no
  // live half is popped from IDLE without raising wr_en.
  always_comb begin
    state_d = state_q;
    en_d    = wr_en;
    addr_d  = wr_addr;
    data_d  = wr_data;
    pop     = 1'b0;
    load    = 1'b0;
    cand    = head;
    case (state_q)
      WB_IDLE: begin
        if (count != '0) begin
          if (has_write(head)) load = 1'b1;
          else                 pop  = 1'b1;
        end
      end
      WB_WR1, WB_WR2: begin
        if (wr_ack) begin
          if (state_q == WB_WR1 && y2_live(head)) begin
            state_d = WB_WR2;
            addr_d  = head.rd2;
            data_d  = head.y2;
          end else begin
            pop = 1'b1;
            if (count > CW'(1) && has_write(next_head)) begin
              load = 1'b1;
              cand = next_head;
            end else begin
              state_d = WB_IDLE;
              en_d    = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = WB_IDLE;
        en_d    = 1'b0;
      end
    endcase
    if (load) begin
      en_d = 1'b1;
      if (cand.rd1 != '0) begin
        state_d = WB_WR1;
        addr_d  = cand.rd1;
        data_d  = cand.y1;
      end else begin
        state_d = WB_WR2;
        addr_d  = cand.rd2;
        data_d  = cand.y2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en   <= en_d;
      wr_addr <= addr_d;
      wr_data <= data_d;
      ready_q <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so a later match overrides an earlier one; within
  // an entry Y2 is checked after Y1. The head's Y1 is already written once
  // the FSM is in WR2, so it no longer counts as pending.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (mem[rd_ptr + PW'(i)].rd1 != '0 && mem[rd_ptr + PW'(i)].rd1 == byp_addr &&
            !(i == 0 && state_q == WB_WR2)) begin
          byp_hit  = 1'b1;
          byp_data = mem[rd_ptr + PW'(i)].y1;
        end
        if (y2_live(mem[rd_ptr + PW'(i)]) && mem[rd_ptr + PW'(i)].rd2 == byp_addr) begin
          byp_hit  = 1'b1;
          byp_data = mem[rd_ptr + PW'(i)].y2;
        end
      end
    end
  end
`else
  logic unused_view;
  assign unused_view = ^{mem, rd_ptr};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenarios plus a randomized phase. The reference
// model is a queue of the register writes that must eventually appear, in
// order, derived from each accepted pair (register-0 halves dropped).
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y1, in_y2;
  logic [4:0]  in_rd1, in_rd2;
  logic        in_dual;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        busy;
  logic [2:0]  count;
  logic [4:0]  byp_addr;
`ifdef WB_BYPASS_EN
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [36:0] exp_q[$];   // {addr, data} of writes still owed
  logic        held_v = 1'b0;
  logic [36:0] held_w;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_y1    (in_y1),
    .in_y2    (in_y2),
    .in_rd1   (in_rd1),
    .in_rd2   (in_rd2),
    .in_dual  (in_dual),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .busy     (busy),
`ifdef WB_BYPASS_EN
    .byp_addr (byp_addr),
    .byp_hit  (byp_hit),
    .byp_data (byp_data),
`endif
    .count    (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic note_fail(input string name);
    total_cnt++;
    $display("FAIL %s", name);
  endtask

  // Compare process: samples 1 time unit before every rising edge.
  task automatic monitor_step();
    logic [36:0] e;
    logic        m_hit;
    logic [31:0] m_data;
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
      return;
    end
    if (held_v) begin
      chk("hold_en", wr_en, 1);
      chk("hold_word", {wr_addr, wr_data}, held_w);
    end
`ifdef WB_BYPASS_EN
    m_hit  = 1'b0;
    m_data = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i][36:32] == byp_addr) begin
        m_hit  = 1'b1;
        m_data = exp_q[i][31:0];
      end
    end
    chk("byp_hit", byp_hit, m_hit);
    if (m_hit) chk("byp_data", byp_data, m_data);
`else
    m_hit  = 1'b0;
    m_data = '0;
`endif
    if (wr_en && wr_ack) begin
      if (exp_q.size() == 0) note_fail("unexpected_write");
      else begin
        e = exp_q.pop_front();
        chk("wr_word", {wr_addr, wr_data}, e);
      end
    end
    held_v = wr_en && !wr_ack;
    held_w = {wr_addr, wr_data};
    if (in_valid && in_ready) begin
      if (in_rd1 != 0) exp_q.push_back({in_rd1, in_y1});
      if (in_dual && in_rd2 != 0) exp_q.push_back({in_rd2, in_y2});
    end
  endtask

  always @(negedge clk) begin
    #4;
    monitor_step();
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [31:0] y1, input logic [31:0] y2,
                      input logic [4:0] r1, input logic [4:0] r2, input logic d);
    int n = 0;
    in_valid = 1'b1; in_y1 = y1; in_y2 = y2; in_rd1 = r1; in_rd2 = r2; in_dual = d;
    #4;
    while (!in_ready && n < 200) begin
      @(negedge clk); #4; n++;
    end
    if (n >= 200) note_fail("push_timeout");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_owed", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_y1 = '0; in_y2 = '0; in_rd1 = '0; in_rd2 = '0;
    in_dual = 1'b0; wr_ack = 1'b0; byp_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-word entry
    wr_ack = 1'b1;
    push(32'h11, 32'h0, 5'd3, 5'd0, 1'b0);
    @(negedge clk);
    chk("single_en", wr_en, 1);
    chk("single_word", {wr_addr, wr_data}, {5'd3, 32'h11});
    @(negedge clk);
    chk("single_done_en", wr_en, 0);
    chk("single_done_busy", busy, 0);

    // Dual entry: consecutive writes
    push(32'hA, 32'hB, 5'd4, 5'd5, 1'b1);
    @(negedge clk);
    chk("dual_first", {wr_en, wr_addr, wr_data}, {1'b1, 5'd4, 32'hA});
    @(negedge clk);
    chk("dual_second", {wr_en, wr_addr, wr_data}, {1'b1, 5'd5, 32'hB});
    @(negedge clk);
    chk("dual_done_busy", busy, 0);

    // Back-pressure: fill, attempt a fifth push, then release
    wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h31 + i, 32'h0, 5'(i + 1), 5'd0, 1'b0);
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_head", {wr_en, wr_addr, wr_data}, {1'b1, 5'd1, 32'h31});
    in_valid = 1'b1; in_y1 = 32'h55; in_rd1 = 5'd9; in_dual = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("fifth_ignored_count", count, 4);
    wr_ack = 1'b1;
    @(negedge clk);
    chk("after_pop_ready", in_ready, 1);
    chk("after_pop_count", count, 3);
    wait_idle();

    // Register-0 halves
    push(32'h66, 32'h77, 5'd0, 5'd7, 1'b1);
    @(negedge clk);
    chk("reg0_skip_y1", {wr_en, wr_addr, wr_data}, {1'b1, 5'd7, 32'h77});
    @(negedge clk);
    push(32'h88, 32'h99, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("reg0_none_en", wr_en, 0);
      @(negedge clk);
    end
    chk("reg0_popped_count", count, 0);

    // Reset in the middle of a write
    wr_ack = 1'b0;
    push(32'h99, 32'h0, 5'd9, 5'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_en", wr_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_en", wr_en, 0);
    chk("mid_rst_count", count, 0);
    rst_n = 1'b1; wr_ack = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_quiet_en", wr_en, 0);
    chk("post_rst_quiet_busy", busy, 0);

`ifdef WB_BYPASS_EN
    wr_ack = 1'b0;
    push(32'h1, 32'h0, 5'd6, 5'd0, 1'b0);
    push(32'h2, 32'h0, 5'd6, 5'd0, 1'b0);
    byp_addr = 5'd6;
    #1;
    chk("byp_literal_hit", byp_hit, 1);
    chk("byp_literal_data", byp_data, 32'h2);
    byp_addr = 5'd7;
    #1;
    chk("byp_literal_miss", byp_hit, 0);
    @(negedge clk);
    wr_ack = 1'b1;
    wait_idle();
`endif

    // Randomized phase
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_y1    = $urandom;
      in_y2    = $urandom;
      in_rd1   = 5'($urandom_range(0, 7));
      in_rd2   = 5'($urandom_range(0, 7));
      in_dual  = $urandom_range(0, 1) == 1;
      wr_ack   = ($urandom_range(0, 99) < 70);
      byp_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wr_ack   = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
